pc_sequencer: RTL and testbench

//  N-bit program-counter register and control FSM; the stage directly upstream of incN.
//  pc_o drives incN.A; incN.C returns on inc_i and becomes the next PC.

---
 rtl/pc_sequencer.sv | 102 ++++++++++
 tb/tb_pc_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter register and run/stall/halt control FSM that feeds an external incN incrementer.
// Define PC_WRAP_HALT_EN to halt on an advance from all-ones instead of wrapping to zero.
module pc_sequencer #(
  parameter int              N          = 8,
  parameter logic [N-1:0]    RESET_ADDR = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         halt_req,
  input  logic         stall,
  input  logic         ld_en,
  input  logic [N-1:0] ld_addr,
  input  logic [N-1:0] inc_i,
  input  logic         pc_ready,
  output logic [N-1:0] pc_o,
  output logic         pc_valid,
  output logic         halted,
  output logic         wrap_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic         wrap_q, wrap_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    wrap_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (halt_req) begin
          state_d = HALT;
        end else begin
          if (ld_en) pc_d = ld_addr;
          if (start) state_d = RUN;
        end
      end

      RUN, STALL: begin
        if (halt_req) begin
          state_d = HALT;
        end else if (ld_en) begin
          // A load drops any un-accepted PC; the state still follows stall.
          pc_d    = ld_addr;
          state_d = stall ? STALL : RUN;
        end else if (stall) begin
          state_d = STALL;
        end else if (state_q == RUN && pc_ready) begin
          if (pc_q == {N{1'b1}}) begin
            wrap_d = 1'b1;
`ifdef PC_WRAP_HALT_EN
            state_d = HALT;
`else
            pc_d = inc_i;
`endif
          end else begin
            pc_d = inc_i;
          end
        end else begin
          state_d = RUN;
        end
      end

      HALT: begin
        state_d = HALT;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; rst is synchronous and overrides every input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_ADDR;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wrap_q  <= wrap_d;
    end
  end

  assign pc_o     = pc_q;
  assign pc_valid = (state_q == RUN);
  assign halted   = (state_q == HALT);
  assign wrap_o   = wrap_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (N=8, RESET_ADDR=0) with an ideal incN model.
// Honours PC_WRAP_HALT_EN when it is defined for the build.
module tb_pc_sequencer;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         halt_req;
  logic         stall;
  logic         ld_en;
  logic [N-1:0] ld_addr;
  logic [N-1:0] inc_i;
  logic         pc_ready;
  logic [N-1:0] pc_o;
  logic         pc_valid;
  logic         halted;
  logic         wrap_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Stand-in for incN: returns pc_o + 1 combinationally.
  assign inc_i = pc_o + 8'd1;

  pc_sequencer #(.N(N), .RESET_ADDR(8'h00)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .halt_req (halt_req),
    .stall    (stall),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .inc_i    (inc_i),
    .pc_ready (pc_ready),
    .pc_o     (pc_o),
    .pc_valid (pc_valid),
    .halted   (halted),
    .wrap_o   (wrap_o)
  );

  // Status word: {pc_o, pc_valid, halted, wrap_o}
  logic [10:0] obs;
  assign obs = {pc_o, pc_valid, halted, wrap_o};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; halt_req = 0; stall = 0; ld_en = 0; ld_addr = '0; pc_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got %h required %h", obs, {8'h00, 3'b000});
    end
  endtask

  task automatic test_count();
    logic [7:0] exp_pc;
    do_reset();
    start = 1; pc_ready = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      exp_pc = 8'(i);
      checks++;
      if (obs !== {exp_pc, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL count[%0d]: got %h required %h", i, obs, {exp_pc, 3'b100});
      end
    end
  endtask

  task automatic test_load_hold();
    // Continues from RUN at pc=4.
    pc_ready = 0; ld_en = 1; ld_addr = 8'h40;
    step();
    checks++;
    if (obs !== {8'h40, 3'b100}) begin
      errors++; $display("FAIL load_40: got %h required %h", obs, {8'h40, 3'b100});
    end
    ld_en = 0;
    step();
    checks++;
    if (obs !== {8'h40, 3'b100}) begin
      errors++; $display("FAIL hold_40: got %h required %h", obs, {8'h40, 3'b100});
    end
    pc_ready = 1;
    step();
    checks++;
    if (obs !== {8'h41, 3'b100}) begin
      errors++; $display("FAIL adv_41: got %h required %h", obs, {8'h41, 3'b100});
    end
  endtask

  task automatic test_wrap();
    // Load wins over an accepted advance in the same cycle.
    pc_ready = 1; ld_en = 1; ld_addr = 8'hFE;
    step();
    checks++;
    if (obs !== {8'hFE, 3'b100}) begin
      errors++; $display("FAIL load_fe: got %h required %h", obs, {8'hFE, 3'b100});
    end
    ld_en = 0;
    step();
    checks++;
    if (obs !== {8'hFF, 3'b100}) begin
      errors++; $display("FAIL adv_ff: got %h required %h", obs, {8'hFF, 3'b100});
    end
    step();
`ifdef PC_WRAP_HALT_EN
    checks++;
    if (obs !== {8'hFF, 3'b011}) begin
      errors++; $display("FAIL wrap_halt: got %h required %h", obs, {8'hFF, 3'b011});
    end
    step();
    checks++;
    if (obs !== {8'hFF, 3'b010}) begin
      errors++; $display("FAIL wrap_halt_stay: got %h required %h", obs, {8'hFF, 3'b010});
    end
`else
    checks++;
    if (obs !== {8'h00, 3'b101}) begin
      errors++; $display("FAIL wrap_00: got %h required %h", obs, {8'h00, 3'b101});
    end
    step();
    checks++;
    if (obs !== {8'h01, 3'b100}) begin
      errors++; $display("FAIL wrap_pulse_end: got %h required %h", obs, {8'h01, 3'b100});
    end
`endif
  endtask

  task automatic test_idle_load();
    do_reset();
    ld_en = 1; ld_addr = 8'h33;
    step();
    checks++;
    if (obs !== {8'h33, 3'b000}) begin
      errors++; $display("FAIL idle_load: got %h required %h", obs, {8'h33, 3'b000});
    end
    ld_en = 0; start = 1; pc_ready = 0;
    step();
    checks++;
    if (obs !== {8'h33, 3'b100}) begin
      errors++; $display("FAIL idle_load_start: got %h required %h", obs, {8'h33, 3'b100});
    end
  endtask

  task automatic test_stall();
    do_reset();
    start = 1; ld_en = 1; ld_addr = 8'h10; pc_ready = 1;
    step();
    checks++;
    if (obs !== {8'h10, 3'b100}) begin
      errors++; $display("FAIL start_load_10: got %h required %h", obs, {8'h10, 3'b100});
    end
    ld_en = 0; stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== {8'h10, 3'b000}) begin
        errors++; $display("FAIL stall[%0d]: got %h required %h", i, obs, {8'h10, 3'b000});
      end
    end
    stall = 0;
    step();
    checks++;
    if (obs !== {8'h10, 3'b100}) begin
      errors++; $display("FAIL resume_10: got %h required %h", obs, {8'h10, 3'b100});
    end
    step();
    checks++;
    if (obs !== {8'h11, 3'b100}) begin
      errors++; $display("FAIL resume_11: got %h required %h", obs, {8'h11, 3'b100});
    end
  endtask

  task automatic test_halt();
    ld_en = 1; ld_addr = 8'h22; pc_ready = 0;
    step();
    ld_en = 0; halt_req = 1; pc_ready = 1;
    step();
    checks++;
    if (obs !== {8'h22, 3'b010}) begin
      errors++; $display("FAIL halt_enter: got %h required %h", obs, {8'h22, 3'b010});
    end
    halt_req = 0; start = 1; ld_en = 1; ld_addr = 8'h55;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (obs !== {8'h22, 3'b010}) begin
        errors++; $display("FAIL halt_frozen[%0d]: got %h required %h", i, obs, {8'h22, 3'b010});
      end
    end
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
    checks++;
    if (obs !== {8'h00, 3'b000}) begin
      errors++; $display("FAIL halt_rst: got %h required %h", obs, {8'h00, 3'b000});
    end
  endtask

  task automatic test_rst_priority();
    do_reset();
    start = 1; ld_en = 1; ld_addr = 8'h77; pc_ready = 1;
    step();
    rst = 1; ld_en = 1; ld_addr = 8'h99; halt_req = 1; start = 1;
    step();
    rst = 0; idle_inputs();
    checks++;
    if (obs !== {8'h00, 3'b000}) begin
      errors++; $display("FAIL rst_priority: got %h required %h", obs, {8'h00, 3'b000});
    end
    step();
    checks++;
    if (obs !== {8'h00, 3'b000}) begin
      errors++; $display("FAIL rst_idle_hold: got %h required %h", obs, {8'h00, 3'b000});
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_count();
    test_load_hold();
    test_wrap();
    test_idle_load();
    test_stall();
    test_halt();
    test_rst_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
